// File: rtl/midi_note_source_if.sv
`default_nettype none
// ============================================================================
// midi_note_source_if : raw MIDI byte stream from the UART receiver
// Rev 1.0
// ============================================================================
interface midi_note_source_if;
  logic       midi_valid;
  logic [7:0] midi_data;

  modport master (output midi_valid, output midi_data);
  modport slave  (input  midi_valid, input  midi_data);
endinterface
`default_nettype wire

// File: rtl/midi_note_source.sv
`default_nettype none
// ============================================================================
// midi_note_source : MIDI parser, channel filter and last-note-priority stack
// Rev 1.0
// ============================================================================
module midi_note_source #(
  parameter int CHANNEL = 0,
  parameter int DEPTH   = 4
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         ce,
  midi_note_source_if.slave                 midi,
  output logic                              note_on,
  output logic                              note_repeat,
  output logic [6:0]                        note_start,
  output logic [6:0]                        vel_start,
  output logic [$clog2(DEPTH+1)-1:0]        stack_count
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2
  } state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_status, w_status_nx;
  logic [6:0] r_d1, w_d1_nx;
  logic       w_done;
  logic [6:0] w_m_d1, w_m_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= NO_STATUS;
      r_status <= 8'd0;
      r_d1     <= 7'd0;
    end else begin
      r_state  <= w_state_nx;
      r_status <= w_status_nx;
      r_d1     <= w_d1_nx;
    end
  end

  // Realtime bytes (F8-FF) fall through untouched so they can sit anywhere.
  always_comb begin
    w_state_nx  = r_state;
    w_status_nx = r_status;
    w_d1_nx     = r_d1;
    w_done      = 1'b0;
    w_m_d1      = r_d1;
    w_m_d2      = 7'd0;
    if (midi.midi_valid && (midi.midi_data < 8'hF8)) begin
      if (midi.midi_data[7]) begin
        if (midi.midi_data < 8'hF0) begin
          w_status_nx = midi.midi_data;
          w_state_nx  = WAIT_D1;
        end else begin
          w_status_nx = 8'd0;
          w_state_nx  = NO_STATUS;
        end
      end else begin
        case (r_state)
          WAIT_D1: begin
            w_d1_nx = midi.midi_data[6:0];
            w_m_d1  = midi.midi_data[6:0];
            if ((r_status[7:4] == 4'hC) || (r_status[7:4] == 4'hD)) w_done = 1'b1;
            else                                                    w_state_nx = WAIT_D2;
          end
          WAIT_D2: begin
            w_done     = 1'b1;
            w_m_d2     = midi.midi_data[6:0];
            w_state_nx = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  logic       w_chan_ok;
  logic       r_ev_on, r_ev_off, r_ev_clr;
  logic [6:0] r_ev_note, r_ev_vel;

  assign w_chan_ok = w_done && (r_status[3:0] == CHANNEL[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ev_on   <= 1'b0;
      r_ev_off  <= 1'b0;
      r_ev_clr  <= 1'b0;
      r_ev_note <= 7'd0;
      r_ev_vel  <= 7'd0;
    end else begin
      r_ev_on   <= w_chan_ok && (r_status[7:4] == 4'h9) && (w_m_d2 != 7'd0);
      r_ev_off  <= w_chan_ok && ((r_status[7:4] == 4'h8) ||
                                 ((r_status[7:4] == 4'h9) && (w_m_d2 == 7'd0)));
      r_ev_clr  <= w_chan_ok && (r_status[7:4] == 4'hB) &&
                   ((w_m_d1 == 7'd120) || (w_m_d1 == 7'd123));
      r_ev_note <= w_m_d1;
      r_ev_vel  <= w_m_d2;
    end
  end

  // Stack slot 0 is the oldest entry, slot count-1 is the sounding note.
  logic [DEPTH-1:0][6:0] r_n, r_v, w_n, w_v;
  logic [CW-1:0]         r_count;
  logic                  r_rep, w_rep_nx;
  logic [6:0]            r_note, r_vel, w_note_nx, w_vel_nx;
  logic                  w_hit, w_retrig;
  int                    w_idx, w_cnt;

  always_comb begin
    w_n      = r_n;
    w_v      = r_v;
    w_cnt    = int'(r_count);
    w_hit    = 1'b0;
    w_idx    = 0;
    w_retrig = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(r_count)) && (r_n[i] == r_ev_note)) begin
        w_hit = 1'b1;
        w_idx = i;
      end
    end
    if (r_ev_clr) begin
      w_cnt = 0;
    end else if (r_ev_on && w_hit && (w_idx == w_cnt - 1)) begin
      for (int i = 0; i < DEPTH; i++) if (i == w_idx) w_v[i] = r_ev_vel;
      w_retrig = 1'b1;
    end else if (r_ev_on) begin
      if (w_hit) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= w_idx) begin
            w_n[i] = w_n[i+1];
            w_v[i] = w_v[i+1];
          end
        end
        w_cnt = w_cnt - 1;
      end
      if (w_cnt == DEPTH) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          w_n[i] = w_n[i+1];
          w_v[i] = w_v[i+1];
        end
        w_cnt = w_cnt - 1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i == w_cnt) begin
          w_n[i] = r_ev_note;
          w_v[i] = r_ev_vel;
        end
      end
      w_cnt = w_cnt + 1;
    end else if (r_ev_off && w_hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= w_idx) begin
          w_n[i] = w_n[i+1];
          w_v[i] = w_v[i+1];
        end
      end
      w_cnt = w_cnt - 1;
    end
  end

  // Empty stack keeps the last note/velocity so the envelope can release it.
  always_comb begin
    w_note_nx = r_note;
    w_vel_nx  = r_vel;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == w_cnt - 1) begin
        w_note_nx = w_n[i];
        w_vel_nx  = w_v[i];
      end
    end
    if (w_cnt == 0)    w_rep_nx = 1'b0;
    else if (w_retrig) w_rep_nx = 1'b1;
    else if (ce)       w_rep_nx = 1'b0;
    else               w_rep_nx = r_rep;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n     <= '0;
      r_v     <= '0;
      r_count <= '0;
      r_rep   <= 1'b0;
      r_note  <= 7'd0;
      r_vel   <= 7'd0;
    end else begin
      r_n     <= w_n;
      r_v     <= w_v;
      r_count <= CW'(w_cnt);
      r_rep   <= w_rep_nx;
      r_note  <= w_note_nx;
      r_vel   <= w_vel_nx;
    end
  end

  assign note_on     = (r_count != '0);
  assign note_repeat = r_rep;
  assign note_start  = r_note;
  assign vel_start   = r_vel;
  assign stack_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_midi_note_source.sv
`default_nettype none
// ============================================================================
// tb_midi_note_source : directed self-checking bench for midi_note_source
// Rev 1.0
// ============================================================================
module tb_midi_note_source;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic       note_on, note_repeat;
  logic [6:0] note_start, vel_start;
  logic [2:0] stack_count;
  int         n_cmp = 0;
  int         n_err = 0;

  midi_note_source_if mif ();

  midi_note_source #(.CHANNEL(0), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (rst),
    .ce          (ce),
    .midi        (mif.slave),
    .note_on     (note_on),
    .note_repeat (note_repeat),
    .note_start  (note_start),
    .vel_start   (vel_start),
    .stack_count (stack_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    mif.midi_valid = 1'b1;
    mif.midi_data  = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mif.midi_valid = 1'b0;
    mif.midi_data  = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic on, input int ns, input int vs, input int cnt);
    check({tag, ".on"},  32'(note_on),     32'(on));
    check({tag, ".ns"},  32'(note_start),  32'(ns));
    check({tag, ".vs"},  32'(vel_start),   32'(vs));
    check({tag, ".cnt"}, 32'(stack_count), 32'(cnt));
  endtask

  initial begin
    mif.midi_valid = 1'b0;
    mif.midi_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", 1'b0, 0, 0, 0);
    check("reset.rep", 32'(note_repeat), 32'd0);

    // Basic note-on; first idle edge only decodes
    send(8'h90); send(8'h3C); send(8'h64);
    idle(1);
    check("lat1.on", 32'(note_on), 32'd0);
    idle(1);
    chk("on60", 1'b1, 60, 100, 1);
    send(8'h3C); send(8'h00); idle(2);
    chk("off60_rs", 1'b0, 60, 100, 0);

    // Three held, release top then bottom
    send(8'h3C); send(8'h0A); send(8'h40); send(8'h14); send(8'h43); send(8'h1E); idle(2);
    chk("hold3", 1'b1, 67, 30, 3);
    send(8'h43); send(8'h00); idle(2);
    chk("rel67", 1'b1, 64, 20, 2);
    check("rel67.rep", 32'(note_repeat), 32'd0);
    send(8'h3C); send(8'h00); idle(2);
    chk("rel60", 1'b1, 64, 20, 1);
    send(8'h40); send(8'h00); idle(2);
    chk("rel64", 1'b0, 64, 20, 0);

    // Retrigger with ce low, then single ce pulse clears it
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    send(8'h90); send(8'h3C); send(8'h50); idle(2);
    chk("retrig", 1'b1, 60, 80, 1);
    check("retrig.rep", 32'(note_repeat), 32'd1);
    idle(3);
    check("retrig.hold", 32'(note_repeat), 32'd1);
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    check("retrig.ceclr", 32'(note_repeat), 32'd0);
    // ce high on the set edge: set wins, next ce edge clears
    ce = 1'b1;
    send(8'h3C); send(8'h51); idle(2);
    check("retrig_ce.rep", 32'(note_repeat), 32'd1);
    check("retrig_ce.vs",  32'(vel_start),   32'd81);
    idle(1);
    check("retrig_ce.clr", 32'(note_repeat), 32'd0);
    ce = 1'b0;
    send(8'h3C); send(8'h00); idle(2);
    chk("off_after_retrig", 1'b0, 60, 81, 0);

    // Realtime interleave, foreign channel, sysex clearing running status
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(2);
    chk("realtime", 1'b1, 60, 100, 1);
    send(8'h91); send(8'h3C); send(8'h65); idle(2);
    chk("chan1", 1'b1, 60, 100, 1);
    send(8'hF0); send(8'h3C); send(8'h66); idle(2);
    chk("sysex", 1'b1, 60, 100, 1);
    send(8'hB0); send(8'h7B); send(8'h00); idle(2);
    chk("allnotesoff", 1'b0, 60, 100, 0);

    // Overflow eviction
    send(8'h90);
    send(8'h3C); send(8'h01); send(8'h3D); send(8'h02); send(8'h3E); send(8'h03);
    send(8'h3F); send(8'h04); send(8'h40); send(8'h05); idle(2);
    chk("full", 1'b1, 64, 5, 4);
    send(8'h3C); send(8'h00); idle(2);
    chk("off_evicted", 1'b1, 64, 5, 4);
    send(8'h40); send(8'h00); send(8'h3F); send(8'h00); send(8'h3E); send(8'h00); idle(2);
    chk("down_to_61", 1'b1, 61, 2, 1);
    // Move an inner note to top with new velocity
    send(8'h3C); send(8'h07); send(8'h3D); send(8'h09); idle(2);
    chk("move_top", 1'b1, 61, 9, 2);
    check("move_top.rep", 32'(note_repeat), 32'd0);
    send(8'h3D); send(8'h00); idle(2);
    chk("after_move", 1'b1, 60, 7, 1);
    send(8'hB0); send(8'h78); send(8'h00); idle(2);
    chk("soundoff120", 1'b0, 60, 7, 0);

    // Reset in the middle of a message
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    chk("pre_reset", 1'b1, 60, 100, 1);
    send(8'h90); send(8'h3C);
    @(negedge clk);
    mif.midi_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset", 1'b0, 0, 0, 0);
    send(8'h64); idle(2);
    chk("post_reset", 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/midi_note_source.md
# midi_note_source

Monophonic MIDI note source that drives one channel's envelope/voice pair. Parses a raw MIDI byte stream (running status, realtime interleave), filters one channel, keeps a last-note-priority held-note stack, and presents `note_on`, `note_repeat`, `note_start` and `vel_start` in the form the envelope block samples on its clock enable. Sits between the MIDI UART receiver and the per-channel envelope/oscillator.

## Interface
- `CHANNEL`, 0: MIDI channel (0-15) accepted; all other channels are parsed and discarded.
- `DEPTH`, 4: held-note stack depth (2-8).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  envelope clock enable; same strobe fed to the envelope `en`.
- `midi_valid`  in  1  one-cycle strobe, `midi_data` valid.
- `midi_data`  in  8  received MIDI byte.
- `note_on`  out  1  level: at least one note held.
- `note_repeat`  out  1  retrigger request for the currently sounding note.
- `note_start`  out  7  sounding note number.
- `vel_start`  out  7  velocity of the sounding note.
- `stack_count`  out  $clog2(DEPTH+1)  number of held notes.

## Operation
- Parser states: NO_STATUS, WAIT_D1, WAIT_D2. Reset -> NO_STATUS, running status cleared.
- 0xF8-0xFF (realtime): ignored, no state or running-status change, any position.
- 0x80-0xEF: latch running status; go to WAIT_D1. 0xF0-0xF7: clear running status; NO_STATUS.
- Data byte (bit7=0) in NO_STATUS: discarded. In WAIT_D1: latch d1; for 0xC/0xD types message completes, back to WAIT_D1; otherwise WAIT_D2. In WAIT_D2: message completes, back to WAIT_D1 (running status).
- Completed message acted on only if channel == `CHANNEL`:
  - 0x9n with vel>0: note-on. 0x8n, or 0x9n with vel=0: note-off.
  - 0xBn d1=120 or 123: clear stack (all notes off). Other types: no effect.
- Stack (entries {note, vel}, top = most recent):
  - Note-on, note absent: push on top; if full, drop oldest entry first.
  - Note-on, note present but not top: remove it, push on top with new velocity.
  - Note-on, note already top: update velocity, set `note_repeat`.
  - Note-off, note present: remove, compact remaining entries preserving order. Absent: ignored.
- Outputs: `note_on` = (count>0); `note_start`/`vel_start` = top entry. When count becomes 0, `note_start`/`vel_start` hold last values (envelope needs the old note for release compare).
- Releasing the top with others held: outputs switch to new top, `note_on` stays 1 (note change restarts envelope; no `note_repeat`).
- `note_repeat`: set on top-retrigger; cleared on the first clk edge with `ce`=1 after the set cycle, so the envelope samples it exactly once. Cleared immediately if `note_on` falls or stack is cleared.

## Timing
- Reset: `note_on`=0, `note_repeat`=0, `note_start`=0, `vel_start`=0, `stack_count`=0, stack empty.
- Latency: outputs update on the 2nd clk edge after the completing byte's `midi_valid` (1 cycle decode, 1 cycle stack update). Nothing changes on non-completing bytes.
- `midi_valid` may arrive every cycle; stack update is single-cycle, no backpressure, no byte dropped.
- `ce` and a retrigger in same cycle: set wins; held until the next `ce`.
- Reset mid-message: parser returns to NO_STATUS, partial message lost.
- Stack full, new note: oldest evicted, `stack_count` stays DEPTH.

## Test plan
- Bytes 0x90,0x3C,0x64 -> 2 clk later `note_on`=1, `note_start`=60, `vel_start`=100, `stack_count`=1; then 0x3C,0x00 (running status) -> `note_on`=0, `note_start` holds 60.
- Hold 60,64,67 (vel 10,20,30); release 67 -> `note_start`=64, `vel_start`=20, `note_on` stays 1, `note_repeat` stays 0; release 60 -> top still 64, count 1.
- 0x90,0x3C,0x64 then 0x90,0x3C,0x50 with `ce` every 4 clk -> `note_repeat`=1 until first `ce` edge, `vel_start`=80, count 1.
- 0x90, 0x3C, 0xF8, 0x64 -> note 60 vel 100 accepted; 0x91,0x3C,0x64 with CHANNEL=0 -> no change; 0xF0 then 0x3C,0x64 -> ignored.
- DEPTH=4, notes 60,61,62,63,64 -> count 4, 60 evicted; note-off 60 -> no change; 0xB0,0x7B,0x00 -> count 0, `note_on`=0.
- Assert `reset` mid-message after 0x90,0x3C with a note held -> all outputs 0; following 0x64 discarded.
